// File: rtl/mcc_serial_subtractor.sv
// Multi-cycle subtractor: one 4-bit Manchester borrow-chain slice per clock, valid/ready on both sides.
// Optional MCC_ADDSUB_MODE_EN adds a latched 'sub' select (1 = subtract, 0 = add).
module mcc_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef MCC_ADDSUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSL = WIDTH / 4;
    localparam int unsigned KW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic             c_q;
    logic             sub_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             sub_in;

`ifdef MCC_ADDSUB_MODE_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b1;
`endif

    logic [KW+1:0] base;
    logic [3:0]    a_s;
    logic [3:0]    b_s;
    logic [3:0]    p_s;
    logic [3:0]    g_s;
    logic [3:0]    sum_s;
    logic [4:0]    ch;

    // One slice of the carry chain; b_q already holds ~b when subtracting.
    always_comb begin
        base  = {k_q, 2'b00};
        a_s   = a_q[base +: 4];
        b_s   = b_q[base +: 4];
        p_s   = a_s ^ b_s;
        g_s   = a_s & b_s;
        ch    = '0;
        ch[0] = c_q;
        for (int i = 0; i < 4; i++) begin
            ch[i+1] = g_s[i] | (p_s[i] & ch[i]);
        end
        sum_s  = p_s ^ ch[3:0];
        diff_d = diff_q;
        diff_d[base +: 4] = sum_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= sub_in ? ~b : b;
                        c_q        <= sub_in ? ~bin : bin;
                        sub_q      <= sub_in;
                        k_q        <= '0;
                        diff_q     <= '0;
                        bout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        zero_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    c_q    <= ch[4];
                    diff_q <= diff_d;
                    if (k_q == KW'(NSL - 1)) begin
                        bout_q      <= sub_q ? ~ch[4] : ch[4];
                        // Same-sign effective operands with a sign flip in the result.
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q      <= (diff_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
